la_rstseq: RTL and testbench
============================

# la_rstseq

Reset release sequencer: takes a reset that is already asynchronously asserted and synchronously deasserted, and releases N downstream reset domains one at a time, DELAY cycles apart. It sits directly downstream of the lambda auxlib reset synchronizer, on the same clock. It also reports sequencing status, and optionally supports a software-requested re-sequence.

## Interface
Parameters:
- N, default 4: number of output reset domains; N >= 1.
- DELAY, default 16: clk cycles between successive releases; DELAY >= 1.
- HOLD, default 8: cycles all outputs are held low after a software reset request; HOLD >= 1.

Ports:
- clk  input  1  clock.
- nrst_in  input  1  reset; asynchronous and active-low. Driven by the upstream synchronizer, so deassertion is already synchronous to clk.
- sw_rst  input  1  software re-sequence request, active-high, sampled on clk.
- nrst_out  output  N  per-domain active-low resets; bit k is released k-th.
- busy  output  1  high while a sequence or hold is in progress.
- done  output  1  high once all N domains are released.

## Operation
- States:
  - IDLE: reset state.
  - SEQ: counting toward the next release.
  - HOLD: software hold.
  - DONE: all domains released.
- Internal regs:
  - cnt, width $clog2(max(DELAY,HOLD)), minimum 1 bit.
  - idx, width $clog2(N), minimum 1 bit.
- nrst_in low, at any time and in any state: asynchronous clear.
  - nrst_out = 0, busy = 0, done = 0.
  - state = IDLE, cnt = 0, idx = 0.
- IDLE: first edge with nrst_in high moves the FSM to SEQ with cnt = 0 and idx = 0, and sets busy = 1.
- SEQ: cnt increments each edge. On the edge where cnt == DELAY-1:
  - set nrst_out[idx] = 1 and clear cnt to 0.
  - if idx == N-1: go to DONE, set done = 1 and busy = 0.
  - else: idx increments.
- Released bits stay high until the next asynchronous reset or a software hold.
- DONE: FSM stays in DONE until a software hold or nrst_in low.
- sw_rst sampled high in SEQ or DONE: on the next state, all nrst_out = 0, done = 0, busy = 1, state = HOLD, cnt = 0.
- sw_rst is ignored in IDLE.
- HOLD: cnt increments each edge. On the edge where cnt == HOLD-1, go to SEQ with cnt = 0 and idx = 0.
- sw_rst high while in HOLD clears cnt to 0, which extends the hold.
- sw_rst held high continuously keeps the block in HOLD.
- Every output is driven directly from a flop, with no combinational decode, so outputs are glitch-free.

## Timing
- Edge 0 is the IDLE→SEQ edge. nrst_out[k] rises at edge (k+1)*DELAY.
- done rises on the same edge as nrst_out[N-1], i.e. edge N*DELAY.
- busy is high over edges 0 through N*DELAY-1.
- sw_rst sampled at edge s:
  - outputs are low from edge s.
  - nrst_out[k] rises at edge s+HOLD+(k+1)*DELAY.
- nrst_in falling affects outputs asynchronously, with no clock needed.
- nrst_in rising is seen at the next clk edge (edge 0).

## Configuration
- Macro LA_RSTSEQ_SWRST_EN.
- Defined: sw_rst, the HOLD state and the HOLD counter compare are compiled in, as described above.
- Undefined:
  - the sw_rst port remains present but is ignored, for pin compatibility.
  - the HOLD state is absent and HOLD is unused.
  - DONE is terminal until nrst_in is low.

## Structure
- Package la_rstseq_pkg holds the state enum (IDLE, SEQ, HOLD, DONE) and the cnt/idx width helper function.
- Sub-module la_rstseq_cnt is a loadable up-counter with terminal-compare output, parameterized on width.
  - It is shared by SEQ (compare DELAY-1) and HOLD (compare HOLD-1).
- Top level holds the FSM, idx, and the nrst_out, busy and done registers.

## Test plan
All scenarios use N=4, DELAY=16, HOLD=8 unless stated.
- Power-on: hold nrst_in low for 5 cycles, then release.
  - While nrst_in is low: nrst_out = 4'b0000, busy = 0, done = 0.
  - After release: nrst_out = 0001, 0011, 0111 and 1111 at edges 16, 32, 48 and 64.
  - done rises at edge 64; busy falls at edge 64.
- Mid-sequence reset: pull nrst_in low between edges 20 and 21, with no clock edge in between.
  - nrst_out drops from 0001 to 0000 immediately.
  - Re-release restarts at idx 0, and bit 0 rises 16 edges after the new edge 0.
- Software re-sequence (macro defined): pulse sw_rst for one cycle at edge 100 while in DONE.
  - nrst_out = 0000, done = 0, busy = 1.
  - bit 0 rises at edge 124 and bit 3 at edge 172.
- Hold extension: assert sw_rst at edges 100 and 105.
  - bit 0 rises at edge 129.
- Macro undefined: pulse sw_rst while in DONE.
  - nrst_out stays 1111 and done stays 1.
- Minimum parameters: N=1, DELAY=1.
  - nrst_out[0] and done rise at edge 1.
  - busy is high for exactly one cycle.

Source files
------------

// File: rtl/la_rstseq_pkg.sv
// Shared types and sizing helpers for the la_rstseq reset release sequencer.
package la_rstseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Register width able to hold values 0..max(a,b)-1, never narrower than 1 bit.
  function automatic int unsigned cw(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/la_rstseq_cnt.sv
// Loadable up-counter with a combinational terminal-count compare against a runtime limit.
module la_rstseq_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  output logic         term_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign term_c = (cnt == limit);

endmodule

// File: rtl/la_rstseq.sv
// Reset release sequencer: releases N reset domains DELAY cycles apart.
// Optional software re-sequence (hold then replay) enabled by LA_RSTSEQ_SWRST_EN.
module la_rstseq
  import la_rstseq_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DELAY = 16,
  parameter int unsigned HOLD  = 8
) (
  input  logic         clk,
  input  logic         nrst_in,
  input  logic         sw_rst,
  output logic [N-1:0] nrst_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = cw(DELAY, HOLD);
  localparam int unsigned IW = cw(N, 1);

  state_e        state_q, state_nxt;
  logic [IW-1:0] idx_q, idx_nxt;
  logic [N-1:0]  nrst_nxt;
  logic          busy_nxt, done_nxt;
  logic          cnt_load, cnt_en, term_c;
  logic [CW-1:0] lim;

  la_rstseq_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (nrst_in),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (CW'(0)),
    .limit    (lim),
    .term_c   (term_c)
  );

  always_ff @(posedge clk or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      nrst_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      idx_q    <= idx_nxt;
      nrst_out <= nrst_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

`ifndef LA_RSTSEQ_SWRST_EN
  logic unused_sw_rst;
  assign unused_sw_rst = sw_rst;
`endif

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    nrst_nxt  = nrst_out;
    busy_nxt  = busy;
    done_nxt  = done;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    lim       = CW'(DELAY - 1);
`ifdef LA_RSTSEQ_SWRST_EN
    if (state_q == ST_HOLD) lim = CW'(HOLD - 1);
`endif

    case (state_q)
      ST_IDLE: begin
        state_nxt = ST_SEQ;
        idx_nxt   = '0;
        busy_nxt  = 1'b1;
        cnt_load  = 1'b1;
      end
      ST_SEQ: begin
`ifdef LA_RSTSEQ_SWRST_EN
        if (sw_rst) begin
          state_nxt = ST_HOLD;
          nrst_nxt  = '0;
          done_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          cnt_load  = 1'b1;
        end else
`endif
        if (term_c) begin
          nrst_nxt = nrst_out | (N'(1) << idx_q);
          cnt_load = 1'b1;
          if (idx_q == IW'(N - 1)) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            idx_nxt = idx_q + IW'(1);
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
`ifdef LA_RSTSEQ_SWRST_EN
      // Repeated requests restart the hold count, stretching the hold.
      ST_HOLD: begin
        if (sw_rst) begin
          cnt_load = 1'b1;
        end else if (term_c) begin
          state_nxt = ST_SEQ;
          idx_nxt   = '0;
          cnt_load  = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
`endif
      ST_DONE: begin
`ifdef LA_RSTSEQ_SWRST_EN
        if (sw_rst) begin
          state_nxt = ST_HOLD;
          nrst_nxt  = '0;
          done_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          cnt_load  = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        nrst_nxt  = '0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        cnt_load  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_la_rstseq.sv
// Directed self-checking bench for la_rstseq (default N=4/DELAY=16/HOLD=8 plus an N=1/DELAY=1 instance).
module tb_la_rstseq;

  logic       clk = 1'b0;
  logic       nrst_in = 1'b0;
  logic       sw_rst = 1'b0;
  logic       sw_min = 1'b0;
  logic [3:0] nrst_out;
  logic       busy, done;
  logic [0:0] nrst_min;
  logic       busy_min, done_min;

  int errs = 0;
  int checks = 0;
  int cur = 0;

  always #5 clk = ~clk;

  la_rstseq #(.N(4), .DELAY(16), .HOLD(8)) dut (
    .clk(clk), .nrst_in(nrst_in), .sw_rst(sw_rst),
    .nrst_out(nrst_out), .busy(busy), .done(done)
  );

  la_rstseq #(.N(1), .DELAY(1), .HOLD(1)) dut_min (
    .clk(clk), .nrst_in(nrst_in), .sw_rst(sw_min),
    .nrst_out(nrst_min), .busy(busy_min), .done(done_min)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cur);
    end
  endtask

  // Advance to edge e relative to the latest release, then settle 1 time unit.
  task automatic goto(input int e);
    while (cur < e) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [3:0] n, input logic b, input logic d);
    check({tag, ".nrst"}, 32'(nrst_out), 32'(n));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  // Release reset at the current (off-edge) time; the next posedge is edge 0.
  task automatic release_rst();
    nrst_in = 1'b1;
    cur = -1;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk_main("por_low", 4'b0000, 1'b0, 1'b0);
    check("min_low.nrst", 32'(nrst_min), 32'(0));
    release_rst();

    goto(0);
    chk_main("e0", 4'b0000, 1'b1, 1'b0);
    check("min_e0.nrst", 32'(nrst_min), 32'(0));
    check("min_e0.busy", 32'(busy_min), 32'(1));
    goto(1);
    check("min_e1.nrst", 32'(nrst_min), 32'(1));
    check("min_e1.done", 32'(done_min), 32'(1));
    check("min_e1.busy", 32'(busy_min), 32'(0));
    goto(15); chk_main("e15", 4'b0000, 1'b1, 1'b0);
    goto(16); chk_main("e16", 4'b0001, 1'b1, 1'b0);
    goto(31); chk_main("e31", 4'b0001, 1'b1, 1'b0);
    goto(32); chk_main("e32", 4'b0011, 1'b1, 1'b0);
    goto(48); chk_main("e48", 4'b0111, 1'b1, 1'b0);
    goto(63); chk_main("e63", 4'b0111, 1'b1, 1'b0);
    goto(64); chk_main("e64", 4'b1111, 1'b0, 1'b1);

    // Single-cycle software request at edge 100 while in DONE.
    goto(99);
    sw_rst = 1'b1;
    goto(100);
    sw_rst = 1'b0;
`ifdef LA_RSTSEQ_SWRST_EN
    chk_main("sw_e100", 4'b0000, 1'b1, 1'b0);
    goto(123); chk_main("sw_e123", 4'b0000, 1'b1, 1'b0);
    goto(124); chk_main("sw_e124", 4'b0001, 1'b1, 1'b0);
    goto(171); chk_main("sw_e171", 4'b0111, 1'b1, 1'b0);
    goto(172); chk_main("sw_e172", 4'b1111, 1'b0, 1'b1);
`else
    chk_main("nosw_e100", 4'b1111, 1'b0, 1'b1);
    goto(110); chk_main("nosw_e110", 4'b1111, 1'b0, 1'b1);
`endif

    // Mid-sequence asynchronous reset between edges 20 and 21.
    nrst_in = 1'b0;
    #20;
    release_rst();
    goto(20); chk_main("mid_e20", 4'b0001, 1'b1, 1'b0);
    #3;
    nrst_in = 1'b0;
    #1;
    chk_main("mid_async", 4'b0000, 1'b0, 1'b0);
    release_rst();
    goto(0);  chk_main("mid_re0", 4'b0000, 1'b1, 1'b0);
    goto(15); chk_main("mid_re15", 4'b0000, 1'b1, 1'b0);
    goto(16); chk_main("mid_re16", 4'b0001, 1'b1, 1'b0);
    goto(64); chk_main("mid_re64", 4'b1111, 1'b0, 1'b1);

`ifdef LA_RSTSEQ_SWRST_EN
    // Hold extension: requests at edges 100 and 105.
    goto(99);  sw_rst = 1'b1;
    goto(100); sw_rst = 1'b0;
    goto(104); sw_rst = 1'b1;
    goto(105); sw_rst = 1'b0;
    goto(112); chk_main("ext_e112", 4'b0000, 1'b1, 1'b0);
    goto(128); chk_main("ext_e128", 4'b0000, 1'b1, 1'b0);
    goto(129); chk_main("ext_e129", 4'b0001, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
